apple1_dsp_sender: RTL and testbench

Character transmitter for the display side of the Apple-1 terminal. It drives the terminal's 7-bit character input and the DA (data available) strobe, and completes a four-phase handshake against the terminal's RDA (ready for data) line. A small FIFO lets a host, keyboard model or test source queue characters faster than the terminal consumes them. It sits between the character source and the video terminal core, in place of the PIA port B / CB2 path.

---
 rtl/apple1_dsp_sender.sv | 123 ++++++++++++
 tb/tb_apple1_dsp_sender.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple1_dsp_sender.sv
// Apple-1 display-side character transmitter: a small FIFO feeding a
// four-phase DA/RDA handshake toward the video terminal.
module apple1_dsp_sender #(
    parameter int DEPTH       = 4,
    parameter int DATA_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     cp,
    input  logic                     mr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        dsp_data,
    output logic                     dsp_da,
    input  logic                     dsp_rda,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_STROBE  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    state_t                 r_state;
    logic [DATA_W-1:0]      r_data;
    logic                   r_da;

    logic w_rda_s;
    logic w_push;
    logic w_pop;

    // RDA comes from the terminal's clock domain; only the last stage is trusted.
    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], dsp_rda};
        end
    end

    assign w_rda_s  = r_sync[SYNC_STAGES-1];
    assign in_ready = (r_count < FULL_C) && !mr;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0) && w_rda_s;

    always_ff @(posedge cp) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_da    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_data  <= r_mem[r_rd_ptr];
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_da    <= 1'b1;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    if (!w_rda_s) begin
                        r_da    <= 1'b0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (w_rda_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dsp_data = r_data;
    assign dsp_da   = r_da;
    assign count    = r_count;
    assign busy     = (r_count != '0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_apple1_dsp_sender.sv
// Directed bench for apple1_dsp_sender: handshake timing, FIFO back-pressure,
// ordering, slow terminal, mid-handshake reset and not-ready start.
module tb_apple1_dsp_sender;

    logic       cp = 1'b0;
    logic       mr = 1'b0;
    logic [6:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] dsp_data;
    logic       dsp_da;
    logic       dsp_rda = 1'b1;
    logic       busy;
    logic [2:0] count;

    int checks = 0;
    int failures = 0;

    apple1_dsp_sender #(.DEPTH(4), .DATA_W(7), .SYNC_STAGES(2)) dut (
        .cp       (cp),
        .mr       (mr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dsp_data (dsp_data),
        .dsp_da   (dsp_da),
        .dsp_rda  (dsp_rda),
        .busy     (busy),
        .count    (count)
    );

    always #5 cp = ~cp;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cp);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [6:0] d, input string tag);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        chk({tag, "_accept"}, 32'(n < 100), 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_da(input string tag);
        int n;
        n = 0;
        while (dsp_da !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        chk({tag, "_rise"}, 32'(n < 100), 32'd1);
    endtask

    // Instantly responding terminal: drop RDA, wait for DA to fall, raise RDA.
    task automatic ack(input string tag);
        int n;
        n = 0;
        dsp_rda = 1'b0;
        while (dsp_da !== 1'b0 && n < 20) begin
            tick(1);
            n++;
        end
        chk({tag, "_fall"}, 32'(n < 20), 32'd1);
        dsp_rda = 1'b1;
    endtask

    task automatic deliver(input logic [6:0] exp, input string tag);
        wait_da(tag);
        chk({tag, "_data"}, 32'(dsp_data), 32'(exp));
        ack(tag);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick(1);
            n++;
        end
        chk({tag, "_idle"}, 32'(n < 100), 32'd1);
    endtask

    initial begin
        int seen;

        // Reset state
        #1 mr = 1'b1;
        #1;
        chk("rst_da", 32'(dsp_da), 32'd0);
        chk("rst_data", 32'(dsp_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick(2);
        mr = 1'b0;
        tick(1);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        tick(2);

        // Single character timing
        in_data  = 7'h41;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("s1_count_e0", 32'(count), 32'd1);
        chk("s1_busy_e0", 32'(busy), 32'd1);
        chk("s1_da_e0", 32'(dsp_da), 32'd0);
        tick(1);
        chk("s1_data_e1", 32'(dsp_data), 32'h41);
        chk("s1_da_e1", 32'(dsp_da), 32'd0);
        chk("s1_count_e1", 32'(count), 32'd0);
        tick(1);
        chk("s1_da_e2", 32'(dsp_da), 32'd1);
        dsp_rda = 1'b0;
        tick(2);
        chk("s1_da_hold", 32'(dsp_da), 32'd1);
        tick(1);
        chk("s1_da_fall", 32'(dsp_da), 32'd0);
        dsp_rda = 1'b1;
        tick(2);
        chk("s1_busy_hold", 32'(busy), 32'd1);
        tick(1);
        chk("s1_busy_fall", 32'(busy), 32'd0);
        chk("s1_data_kept", 32'(dsp_data), 32'h41);

        // FIFO fill and back-pressure
        dsp_rda = 1'b0;
        tick(3);
        for (int i = 1; i <= 4; i++) begin
            in_data  = 7'(i);
            in_valid = 1'b1;
            tick(1);
        end
        in_data = 7'h05;
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        tick(2);
        chk("fill_count_held", 32'(count), 32'd4);
        chk("fill_no_da", 32'(dsp_da), 32'd0);
        dsp_rda = 1'b1;
        wait_da("f1");
        in_valid = 1'b0;
        chk("f1_data", 32'(dsp_data), 32'h01);
        chk("f1_refill", 32'(count), 32'd4);
        ack("f1");
        deliver(7'h02, "f2");
        deliver(7'h03, "f3");
        deliver(7'h04, "f4");
        deliver(7'h05, "f5");
        wait_idle("fill");
        chk("fill_empty", 32'(count), 32'd0);

        // Simultaneous push and pop
        dsp_rda = 1'b0;
        tick(3);
        push(7'h31, "sp_a");
        push(7'h32, "sp_b");
        chk("sp_count2", 32'(count), 32'd2);
        dsp_rda = 1'b1;
        tick(2);
        in_data  = 7'h33;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("sp_count_same", 32'(count), 32'd2);
        chk("sp_head", 32'(dsp_data), 32'h31);
        deliver(7'h31, "sp1");
        deliver(7'h32, "sp2");
        deliver(7'h33, "sp3");
        wait_idle("sp");

        // Further pushes carry the pointers into a third wrap
        push(7'h50, "w0");
        push(7'h51, "w1");
        push(7'h52, "w2");
        push(7'h53, "w3");
        deliver(7'h50, "w0");
        deliver(7'h51, "w1");
        deliver(7'h52, "w2");
        deliver(7'h53, "w3");
        wait_idle("wrap");

        // Slow terminal: acceptance delayed 50 cycles after DA rises
        push(7'h55, "sl_a");
        push(7'h56, "sl_b");
        wait_da("sl");
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (dsp_da !== 1'b1 || dsp_data !== 7'h55 || count !== 3'd1) seen++;
            tick(1);
        end
        chk("sl_stable_cycles_bad", 32'(seen), 32'd0);
        chk("sl_count", 32'(count), 32'd1);
        chk("sl_data", 32'(dsp_data), 32'h55);
        ack("sl");
        deliver(7'h56, "sl2");
        wait_idle("sl");

        // Reset while strobing with three queued
        dsp_rda = 1'b0;
        tick(3);
        push(7'h61, "rm0");
        push(7'h62, "rm1");
        push(7'h63, "rm2");
        push(7'h64, "rm3");
        dsp_rda = 1'b1;
        wait_da("rm");
        chk("rm_count3", 32'(count), 32'd3);
        chk("rm_data", 32'(dsp_data), 32'h61);
        mr = 1'b1;
        #1;
        chk("rm_da", 32'(dsp_da), 32'd0);
        chk("rm_data0", 32'(dsp_data), 32'd0);
        chk("rm_count0", 32'(count), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_in_ready", 32'(in_ready), 32'd0);
        dsp_rda = 1'b0;
        tick(2);
        chk("rm_in_ready_held", 32'(in_ready), 32'd0);
        mr = 1'b0;
        tick(1);
        chk("rm_in_ready_rel", 32'(in_ready), 32'd1);
        chk("rm_busy_rel", 32'(busy), 32'd0);

        // Terminal not ready at start
        tick(2);
        push(7'h7F, "nr");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (dsp_da !== 1'b0) seen++;
            tick(1);
        end
        chk("nr_no_pulse", 32'(seen), 32'd0);
        chk("nr_count", 32'(count), 32'd1);
        dsp_rda = 1'b1;
        tick(3);
        chk("nr_da_early", 32'(dsp_da), 32'd0);
        tick(1);
        chk("nr_da_rise", 32'(dsp_da), 32'd1);
        chk("nr_data", 32'(dsp_data), 32'h7F);
        ack("nr");
        wait_idle("nr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
